// File: rtl/conv_mac_tree_pkg.sv
// ============================================================================
// conv_pkg : shared fixed-point types and pipeline geometry helpers
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package conv_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_FRAC_BITS  = 6;
  localparam int DEF_KERNEL     = 5;

  typedef logic signed [DEF_DATA_WIDTH-1:0] fx_t;

  typedef struct packed {
    fx_t  data;
    logic sat;
  } fx_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int n_term(input int k);
    return k * k + 1;
  endfunction

  function automatic int add_stages(input int k);
    return clog2(n_term(k));
  endfunction

  function automatic int latency(input int k);
    return add_stages(k) + 2;
  endfunction

  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + clog2(n_term(k));
  endfunction

  // Number of operands at tree level s (level 0 = leaves); odd leftovers ride along.
  function automatic int level_cnt(input int n, input int s);
    return (n + (1 << s) - 1) >> s;
  endfunction

  function automatic int level_off(input int n, input int s);
    int o;
    o = 0;
    for (int j = 0; j < s; j++) o += level_cnt(n, j);
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac_tree_if.sv
// ============================================================================
// conv_mac_tree_if : window/weight input stream and result output stream
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

interface conv_mac_tree_if
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KERNEL     = DEF_KERNEL
);
  localparam int N_TAP = KERNEL * KERNEL;

  logic                          in_valid;
  logic                          in_ready;
  logic [N_TAP*DATA_WIDTH-1:0]   pixel_bus;
  logic [N_TAP*DATA_WIDTH-1:0]   weight_bus;
  logic [DATA_WIDTH-1:0]         bias;
  logic                          relu_en;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_sat;

  modport master (
    output in_valid, pixel_bus, weight_bus, bias, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, pixel_bus, weight_bus, bias, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

`default_nettype wire

// File: rtl/conv_mac_tree_round_sat.sv
// ============================================================================
// fx_round_sat : round-half-up, drop FRAC_BITS, saturate to OUT_W with flag
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module fx_round_sat
  import conv_pkg::*;
#(
  parameter int IN_W      = 29,
  parameter int OUT_W     = DEF_DATA_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic signed [IN_W-1:0]  acc_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  // One guard bit keeps the rounding add from overflowing at the top of range.
  localparam logic signed [IN_W:0] c_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] c_MIN = ~c_MAX;

  logic signed [IN_W:0] ext_w;
  logic signed [IN_W:0] rnd_w;
  logic signed [IN_W:0] shr_w;

  assign ext_w = {acc_i[IN_W-1], acc_i};

  if (FRAC_BITS > 0) begin : g_round
    localparam logic signed [IN_W:0] c_HALF = {{IN_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    assign rnd_w = ext_w + c_HALF;
  end else begin : g_no_round
    assign rnd_w = ext_w;
  end

  assign shr_w = rnd_w >>> FRAC_BITS;

  always_comb begin
    data_o = shr_w[OUT_W-1:0];
    sat_o  = 1'b0;
    if (shr_w > c_MAX) begin
      data_o = c_MAX[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (shr_w < c_MIN) begin
      data_o = c_MIN[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_mac_tree.sv
// ============================================================================
// conv_mac_tree : KxK window MAC, pipelined multiply + balanced adder tree
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int KERNEL     = DEF_KERNEL
) (
  input  logic            clk,
  input  logic            rst_n,
  conv_mac_tree_if.slave  bus_if
);

  localparam int N_TAP      = KERNEL * KERNEL;
  localparam int N_TERM     = n_term(KERNEL);
  localparam int ADD_STAGES = add_stages(KERNEL);
  localparam int LATENCY    = latency(KERNEL);
  localparam int ACC_W      = acc_width(DATA_WIDTH, KERNEL);
  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int N_NODE     = level_off(N_TERM, ADD_STAGES + 1);
  localparam int ROOT       = level_off(N_TERM, ADD_STAGES);

  // All tree levels live in one flat vector; level s starts at level_off(N_TERM, s).
  logic [N_NODE-1:0][ACC_W-1:0] node_d;
  logic [N_NODE-1:0][ACC_W-1:0] node_q;
  logic [LATENCY-1:0]           vld_q;
  logic [LATENCY-2:0]           relu_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic                         sat_q;
  logic                         en_w;
  logic [ACC_W-1:0]             bias_ext_w;
  logic signed [DATA_WIDTH-1:0] rs_data_w;
  logic                         rs_sat_w;

  assign en_w            = !vld_q[LATENCY-1] || bus_if.out_ready;
  assign bus_if.in_ready = en_w;

  for (genvar i = 0; i < N_TAP; i++) begin : g_leaf
    logic signed [DATA_WIDTH-1:0] pix_w;
    logic signed [DATA_WIDTH-1:0] wgt_w;
    logic signed [PROD_W-1:0]     prod_w;
    assign pix_w     = bus_if.pixel_bus[i*DATA_WIDTH +: DATA_WIDTH];
    assign wgt_w     = bus_if.weight_bus[i*DATA_WIDTH +: DATA_WIDTH];
    assign prod_w    = pix_w * wgt_w;
    assign node_d[i] = {{(ACC_W-PROD_W){prod_w[PROD_W-1]}}, prod_w};
  end

  assign bias_ext_w     = {{(ACC_W-DATA_WIDTH){bus_if.bias[DATA_WIDTH-1]}}, bus_if.bias};
  assign node_d[N_TAP]  = bias_ext_w << FRAC_BITS;

  for (genvar s = 1; s <= ADD_STAGES; s++) begin : g_lvl
    localparam int N_IN    = level_cnt(N_TERM, s - 1);
    localparam int IN_OFF  = level_off(N_TERM, s - 1);
    localparam int OUT_OFF = level_off(N_TERM, s);
    for (genvar j = 0; j < level_cnt(N_TERM, s); j++) begin : g_node
      if (2 * j + 1 < N_IN) begin : g_add
        assign node_d[OUT_OFF+j] = node_q[IN_OFF+2*j] + node_q[IN_OFF+2*j+1];
      end else begin : g_pass
        assign node_d[OUT_OFF+j] = node_q[IN_OFF+2*j];
      end
    end
  end

  fx_round_sat #(
    .IN_W      (ACC_W),
    .OUT_W     (DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .acc_i  (node_q[ROOT]),
    .data_o (rs_data_w),
    .sat_o  (rs_sat_w)
  );

  // Whole pipeline advances together; a stall freezes every stage in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      node_q <= '0;
      vld_q  <= '0;
      relu_q <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (en_w) begin
      node_q <= node_d;
      vld_q  <= {vld_q[LATENCY-2:0], bus_if.in_valid};
      relu_q <= {relu_q[LATENCY-3:0], bus_if.relu_en};
      data_q <= (relu_q[LATENCY-2] && rs_data_w[DATA_WIDTH-1]) ? '0 : rs_data_w;
      sat_q  <= rs_sat_w;
    end
  end

  assign bus_if.out_valid = vld_q[LATENCY-1];
  assign bus_if.out_data  = data_q;
  assign bus_if.out_sat   = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_tree.sv
// ============================================================================
// tb_conv_mac_tree : directed table, back-to-back, random stream, reset flush
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_conv_mac_tree;
  import conv_pkg::*;

  localparam int DW    = 12;
  localparam int FRAC  = 6;
  localparam int K     = 5;
  localparam int N_TAP = K * K;
  localparam int LAT   = 7;

  typedef struct {
    logic [N_TAP*DW-1:0] pix;
    logic [N_TAP*DW-1:0] wgt;
    logic [DW-1:0]       bias;
    bit                  relu;
    fx_t                 exp_d;
    bit                  exp_s;
  } vec_t;

  typedef struct {
    fx_t d;
    bit  s;
    int  cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  conv_mac_tree_if #(.DATA_WIDTH(DW), .KERNEL(K)) bus_if ();

  conv_mac_tree #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC), .KERNEL(K)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc     = 0;
  bit      chk_lat = 0;
  bit      stall_chk = 0;
  bit      last_acc = 0;
  bit      hold_prev = 0;
  fx_t     hold_d;
  fx_res_t cur_exp;
  exp_t    exp_q[$];
  vec_t    tbl[13];

  task automatic check(input string name, input longint act, input longint exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: exact sum of products plus scaled bias, floor((acc + half) / 2^FRAC), clamp, ReLU.
  function automatic fx_res_t model(input logic [N_TAP*DW-1:0] pix, input logic [N_TAP*DW-1:0] wgt,
                                    input logic [DW-1:0] b, input logic relu);
    longint  acc, q;
    longint  scale, maxv, minv;
    fx_res_t r;
    scale = 2 ** FRAC;
    maxv  = 2 ** (DW - 1) - 1;
    minv  = -(2 ** (DW - 1));
    acc   = longint'($signed(b)) * scale;
    for (int i = 0; i < N_TAP; i++)
      acc += longint'($signed(pix[i*DW +: DW])) * longint'($signed(wgt[i*DW +: DW]));
    acc  += scale / 2;
    q     = (acc >= 0) ? acc / scale : -((-acc + scale - 1) / scale);
    r.sat = 1'b0;
    if (q > maxv) begin
      q = maxv; r.sat = 1'b1;
    end else if (q < minv) begin
      q = minv; r.sat = 1'b1;
    end
    if (relu && q < 0) q = 0;
    r.data = q[DW-1:0];
    return r;
  endfunction

  function automatic vec_t mk(input int p, input int w, input int b, input bit r, input bit tap0,
                              input int ed, input bit es);
    vec_t          v;
    logic [DW-1:0] pv, wv;
    pv = DW'(p);
    wv = DW'(w);
    if (tap0) begin
      v.pix = '0; v.wgt = '0;
      v.pix[DW-1:0] = pv; v.wgt[DW-1:0] = wv;
    end else begin
      v.pix = {N_TAP{pv}}; v.wgt = {N_TAP{wv}};
    end
    v.bias = DW'(b); v.relu = r; v.exp_d = DW'(ed); v.exp_s = es;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus_if.pixel_bus  = v.pix;
    bus_if.weight_bus = v.wgt;
    bus_if.bias       = v.bias;
    bus_if.relu_en    = v.relu;
    cur_exp.data      = v.exp_d;
    cur_exp.sat       = v.exp_s;
  endtask

  task automatic rand_window();
    int m, t;
    case ($urandom_range(0, 2))
      0:       m = 8;
      1:       m = 40;
      default: m = 2047;
    endcase
    for (int i = 0; i < N_TAP; i++) begin
      t = int'($urandom_range(0, 2 * m)) - m;
      bus_if.pixel_bus[i*DW +: DW] = DW'(t);
      t = int'($urandom_range(0, 2 * m)) - m;
      bus_if.weight_bus[i*DW +: DW] = DW'(t);
    end
    t = int'($urandom_range(0, 2 * m)) - m;
    bus_if.bias    = DW'(t);
    bus_if.relu_en = 1'($urandom_range(0, 1));
    cur_exp = model(bus_if.pixel_bus, bus_if.weight_bus, bus_if.bias, bus_if.relu_en);
  endtask

  // Called at a negedge with inputs already set; scores this cycle, then moves to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (hold_prev) begin
      check("hold_valid", bus_if.out_valid, 1);
      check("hold_data", $signed(bus_if.out_data), hold_d);
    end
    if (stall_chk) check("stall_in_ready", bus_if.in_ready, 0);
    if (bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", bus_if.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", $signed(bus_if.out_data), e.d);
        check("out_sat", bus_if.out_sat, e.s);
        if (chk_lat) check("latency", cyc - e.cyc, LAT);
      end
    end
    hold_prev = bus_if.out_valid && !bus_if.out_ready;
    hold_d    = bus_if.out_data;
    last_acc  = bus_if.in_valid && bus_if.in_ready;
    if (last_acc) exp_q.push_back('{cur_exp.data, cur_exp.sat, cyc});
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
    check("drain_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int rd_sent, stall_left, stale;
    bit pend, stall_done;

    tbl[0]  = mk(  64,   64, 0, 0, 0,  1600, 0);
    tbl[1]  = mk(  64,  127, 0, 0, 0,  2047, 1);
    tbl[2]  = mk(  64, -128, 0, 0, 0, -2048, 1);
    tbl[3]  = mk(  64,  -64, 0, 0, 0, -1600, 0);
    tbl[4]  = mk(  64,  -64, 0, 1, 0,     0, 0);
    tbl[5]  = mk(   1,   32, 0, 0, 1,     1, 0);
    tbl[6]  = mk(   1,  -32, 0, 0, 1,     0, 0);
    tbl[7]  = mk(   1,   31, 0, 0, 1,     0, 0);
    tbl[8]  = mk(   0,    0, 5, 0, 1,     5, 0);
    tbl[9]  = mk(  64, -128, 0, 1, 0,     0, 1);
    tbl[10] = mk(  64,  127, 0, 1, 0,  2047, 1);
    tbl[11] = mk(   1,  -33, 0, 0, 1,    -1, 0);
    tbl[12] = mk(   1,   33, 0, 0, 1,     1, 0);

    rst_n = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    apply(tbl[0]);
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_out_data", bus_if.out_data, 0);
    check("rst_out_sat", bus_if.out_sat, 0);
    check("rst_in_ready", bus_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    chk_lat = 1;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      drain();
    end

    // Back-to-back with relu_en toggling every sample.
    for (int k = 0; k < 4; k++) begin
      apply(tbl[3 + (k % 2)]);
      bus_if.in_valid = 1'b1;
      tick();
    end
    bus_if.in_valid = 1'b0;
    drain();

    // Random stream with bubbles and one 4-cycle downstream stall.
    chk_lat = 0;
    rd_sent = 0; pend = 0; stall_left = 0; stall_done = 0;
    for (int c = 0; c < 600 && (rd_sent < 20 || exp_q.size() > 0); c++) begin
      if (!pend && rd_sent < 20 && $urandom_range(0, 4) != 0) begin
        rand_window();
        pend = 1;
      end
      bus_if.in_valid = pend;
      if (rd_sent >= 8 && !stall_done && stall_left == 0 && bus_if.out_valid) stall_left = 4;
      bus_if.out_ready = (stall_left == 0);
      stall_chk = (stall_left > 0);
      tick();
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall_done = 1;
      end
      if (last_acc) begin
        pend = 0;
        rd_sent++;
      end
    end
    stall_chk = 0;
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    check("rand_sent", rd_sent, 20);
    check("rand_stall_seen", stall_done, 1);
    drain();

    // Reset with five samples in flight: nothing may emerge afterwards.
    for (int k = 0; k < 5; k++) begin
      rand_window();
      bus_if.in_valid = 1'b1;
      tick();
    end
    bus_if.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    hold_prev = 0;
    #1;
    check("midrst_out_valid", bus_if.out_valid, 0);
    check("midrst_out_data", bus_if.out_data, 0);
    check("midrst_in_ready", bus_if.in_ready, 1);
    @(negedge clk);
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus_if.out_valid) stale++;
      tick();
    end
    check("midrst_stale_outputs", stale, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
